// File: rtl/cover_toggle_collector_if.sv
// Port bundle of the toggle-coverage collector: hit strobes and restart in,
// newly-covered index stream (valid/ready) and coverage status out.
interface cover_toggle_collector_if #(
  parameter int WIDTH = 19
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] valid;
  logic             clear;
  logic             out_ready;
  logic             out_valid;
  logic [63:0]      out_index;
  logic [CNT_W-1:0] covered_cnt;
  logic             all_covered;

  modport master (
    output valid, clear, out_ready,
    input  out_valid, out_index, covered_cnt, all_covered
  );

  modport slave (
    input  valid, clear, out_ready,
    output out_valid, out_index, covered_cnt, all_covered
  );
endinterface

// File: rtl/cover_toggle_collector.sv
// Toggle-coverage collector: records first hits per point and streams each
// newly covered point's global index exactly once, lowest bit first.
module cover_toggle_collector #(
  parameter int          WIDTH       = 19,
  parameter logic [63:0] COVER_INDEX = 64'd0,
  parameter int          COVER_TOTAL = 28338
) (
  input logic                     gbl_clk,
  input logic                     reset,
  cover_toggle_collector_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int SEL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // The total is informational; only reject a nonsensical value at elaboration.
  if (COVER_TOTAL < 1) begin : g_total_check
    $error("cover_toggle_collector: COVER_TOTAL must be positive");
  end

  logic [WIDTH-1:0] covered_q, covered_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             out_valid_q, out_valid_d;
  logic [63:0]      out_index_q, out_index_d;
  logic [CNT_W-1:0] covered_cnt_q, covered_cnt_d;
  logic             all_covered_q, all_covered_d;

  logic [WIDTH-1:0] new_hits;
  logic [WIDTH-1:0] cand;
  logic [SEL_W-1:0] sel;
  logic [CNT_W-1:0] hit_cnt;
  logic             load;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    new_hits = bus.valid & ~covered_q;
    cand     = pending_q | new_hits;

    // Descending scan so the last assignment wins: lowest set bit has priority.
    sel = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (cand[i]) sel = SEL_W'(i);
    end

    hit_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      hit_cnt = hit_cnt + CNT_W'(new_hits[i]);
    end

    load = (!out_valid_q || bus.out_ready) && (|cand);

    covered_d     = covered_q | bus.valid;
    covered_cnt_d = covered_cnt_q + hit_cnt;
    all_covered_d = &covered_d;
    pending_d     = pending_q | new_hits;
    out_valid_d   = out_valid_q;
    out_index_d   = out_index_q;

    if (load) begin
      pending_d   = cand & ~(WIDTH'(1) << sel);
      out_valid_d = 1'b1;
      out_index_d = COVER_INDEX + 64'(sel);
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    // Restart discards this cycle's hits along with all accumulated state.
    if (bus.clear) begin
      covered_d     = '0;
      covered_cnt_d = '0;
      all_covered_d = 1'b0;
      pending_d     = '0;
      out_valid_d   = 1'b0;
      out_index_d   = '0;
    end
  end

  // NOTE: state flops use non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge gbl_clk) begin
    if (!reset) begin
      covered_q     <= '0;
      pending_q     <= '0;
      out_valid_q   <= 1'b0;
      out_index_q   <= '0;
      covered_cnt_q <= '0;
      all_covered_q <= 1'b0;
    end else begin
      covered_q     <= covered_d;
      pending_q     <= pending_d;
      out_valid_q   <= out_valid_d;
      out_index_q   <= out_index_d;
      covered_cnt_q <= covered_cnt_d;
      all_covered_q <= all_covered_d;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_index   = out_index_q;
  assign bus.covered_cnt = covered_cnt_q;
  assign bus.all_covered = all_covered_q;
endmodule

// File: tb/tb_cover_toggle_collector.sv
// Self-checking bench for cover_toggle_collector: a scoreboard of expected
// indices checks the output stream, plus direct status/latency checks.
module tb_cover_toggle_collector;
  localparam int          WIDTH = 19;
  localparam logic [63:0] CIDX  = 64'd100;

  logic gbl_clk = 1'b0;
  logic reset   = 1'b0;
  always #5 gbl_clk = ~gbl_clk;

  cover_toggle_collector_if #(.WIDTH(WIDTH)) bus ();

  cover_toggle_collector #(
    .WIDTH      (WIDTH),
    .COVER_INDEX(CIDX),
    .COVER_TOTAL(28338)
  ) dut (
    .gbl_clk(gbl_clk),
    .reset  (reset),
    .bus    (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0]      exp_q[$];
  logic [WIDTH-1:0] model_cov = '0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge gbl_clk);
    #1;
  endtask

  // Expect one index per point not yet covered, ascending within the mask.
  task automatic push_hits(input logic [WIDTH-1:0] mask);
    for (int i = 0; i < WIDTH; i++) begin
      if (mask[i] && !model_cov[i]) exp_q.push_back(CIDX + 64'(i));
    end
    model_cov = model_cov | mask;
  endtask

  task automatic do_clear(input logic [WIDTH-1:0] v);
    bus.out_ready = 1'b0;
    bus.clear     = 1'b1;
    bus.valid     = v;
    tick(1);
    bus.clear = 1'b0;
    bus.valid = '0;
    exp_q.delete();
    model_cov = '0;
  endtask

  function automatic int popcnt(input logic [WIDTH-1:0] m);
    int c = 0;
    for (int i = 0; i < WIDTH; i++) c += int'(m[i]);
    return c;
  endfunction

  // Monitor: handshake pops the scoreboard; a stalled output must hold.
  logic        prev_stall = 1'b0;
  logic [63:0] prev_idx   = '0;
  always @(negedge gbl_clk) begin
    logic [63:0] exp;
    if (reset && !bus.clear && bus.out_valid && bus.out_ready) begin
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      check_eq("emit_index", bus.out_index, exp);
    end
    if (reset && !bus.clear && prev_stall) begin
      check_eq("stall_valid", 64'(bus.out_valid), 64'd1);
      check_eq("stall_index", bus.out_index, prev_idx);
    end
    prev_stall = reset && !bus.clear && bus.out_valid && !bus.out_ready;
    prev_idx   = bus.out_index;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.valid     = '0;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b0;
    bus.valid     = 19'h7FFFF;  // must be discarded while in reset
    tick(2);
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_out_index", bus.out_index, 64'd0);
    check_eq("rst_cnt", 64'(bus.covered_cnt), 64'd0);
    check_eq("rst_all", 64'(bus.all_covered), 64'd0);
    bus.valid = '0;
    reset     = 1'b1;
    tick(2);
    check_eq("post_rst_idle", 64'(bus.out_valid), 64'd0);

    // Single hit on bit 2: index 102 appears one cycle later, then idle.
    bus.out_ready = 1'b1;
    bus.valid     = 19'h00004;
    push_hits(19'h00004);
    tick(1);
    bus.valid = '0;
    check_eq("lat_valid", 64'(bus.out_valid), 64'd1);
    check_eq("lat_index", bus.out_index, 64'd102);
    tick(1);
    check_eq("lat_drop", 64'(bus.out_valid), 64'd0);
    check_eq("lat_cnt", 64'(bus.covered_cnt), 64'd1);

    // All points at once: 19 consecutive ascending indices.
    do_clear('0);
    check_eq("clr_cnt", 64'(bus.covered_cnt), 64'd0);
    bus.out_ready = 1'b1;
    bus.valid     = 19'h7FFFF;
    push_hits(19'h7FFFF);
    tick(1);
    bus.valid = '0;
    check_eq("burst_all", 64'(bus.all_covered), 64'd1);
    check_eq("burst_cnt", 64'(bus.covered_cnt), 64'd19);
    for (int i = 0; i < WIDTH; i++) begin
      check_eq("burst_valid", 64'(bus.out_valid), 64'd1);
      tick(1);
    end
    check_eq("burst_end", 64'(bus.out_valid), 64'd0);
    check_eq("burst_drained", 64'(exp_q.size()), 64'd0);

    // Backpressure: index 100 held for 5 cycles, then 100 and 101 once each.
    do_clear('0);
    bus.valid = 19'h00003;
    push_hits(19'h00003);
    tick(1);
    bus.valid = '0;
    tick(5);
    check_eq("bp_valid", 64'(bus.out_valid), 64'd1);
    check_eq("bp_index", bus.out_index, 64'd100);
    bus.out_ready = 1'b1;
    tick(1);
    check_eq("bp_second", bus.out_index, 64'd101);
    tick(1);
    check_eq("bp_end", 64'(bus.out_valid), 64'd0);
    check_eq("bp_drained", 64'(exp_q.size()), 64'd0);

    // Repeated hits on one point report it once.
    do_clear('0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.valid = 19'h00001;
      push_hits(19'h00001);
      tick(1);
    end
    bus.valid = '0;
    tick(2);
    check_eq("rep_cnt", 64'(bus.covered_cnt), 64'd1);
    check_eq("rep_drained", 64'(exp_q.size()), 64'd0);

    // Clear drops in-flight work and ignores same-cycle hits.
    do_clear('0);
    bus.valid = 19'h00030;
    push_hits(19'h00030);
    tick(1);
    bus.valid = '0;
    tick(1);
    do_clear(19'h00001);
    check_eq("clr2_valid", 64'(bus.out_valid), 64'd0);
    check_eq("clr2_index", bus.out_index, 64'd0);
    check_eq("clr2_cnt", 64'(bus.covered_cnt), 64'd0);
    check_eq("clr2_all", 64'(bus.all_covered), 64'd0);
    bus.out_ready = 1'b1;
    tick(2);
    check_eq("clr2_quiet", 64'(bus.out_valid), 64'd0);
    bus.valid = 19'h00010;
    push_hits(19'h00010);
    tick(1);
    bus.valid = '0;
    check_eq("clr2_reemit", bus.out_index, 64'd104);
    tick(1);
    check_eq("clr2_cnt1", 64'(bus.covered_cnt), 64'd1);

    // Reset mid-burst with five outstanding indices.
    do_clear('0);
    bus.valid = 19'h0001F;
    push_hits(19'h0001F);
    tick(1);
    bus.valid = '0;
    tick(1);
    reset     = 1'b0;
    bus.valid = 19'h00040;
    tick(1);
    check_eq("mrst_valid", 64'(bus.out_valid), 64'd0);
    check_eq("mrst_index", bus.out_index, 64'd0);
    check_eq("mrst_cnt", 64'(bus.covered_cnt), 64'd0);
    exp_q.delete();
    model_cov     = '0;
    reset         = 1'b1;
    bus.valid     = '0;
    bus.out_ready = 1'b1;
    tick(5);
    check_eq("mrst_quiet", 64'(bus.out_valid), 64'd0);
    check_eq("mrst_cnt0", 64'(bus.covered_cnt), 64'd0);
    bus.valid = 19'h00002;
    push_hits(19'h00002);
    tick(1);
    bus.valid = '0;
    check_eq("mrst_new", bus.out_index, 64'd101);
    tick(2);
    check_eq("mrst_cnt_model", 64'(bus.covered_cnt), 64'(popcnt(model_cov)));

    check_eq("final_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cover_toggle_collector.md
COVER_TOGGLE_COLLECTOR -- requirements
Module: cover_toggle_collector

Interface
REQ-001 SHALL have parameter WIDTH, default 19, number of toggle points in the group.
REQ-002 SHALL have parameter COVER_INDEX, default 0, global index of bit 0 of the group.
REQ-003 SHALL have parameter COVER_TOTAL, default 28338, total cover points, informational only.
REQ-004 gbl_clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-low.
REQ-006 valid  input  WIDTH  per-point toggle-hit strobes for this cycle.
REQ-007 clear  input  1  synchronous coverage restart, active-high.
REQ-008 out_ready  input  1  downstream consumer accepts out_index this cycle.
REQ-009 out_valid  output  1  out_index holds a newly covered point.
REQ-010 out_index  output  64  global cover index (COVER_INDEX + bit position).
REQ-011 covered_cnt  output  $clog2(WIDTH+1)  number of distinct points covered since reset/clear.
REQ-012 all_covered  output  1  high when every point is covered.

Function
REQ-013 SHALL hold a WIDTH-bit covered bitmap; covered_next = covered | valid.
REQ-014 SHALL define new_hits = valid & ~covered; each point SHALL be reported at most once between resets/clears.
REQ-015 SHALL hold a WIDTH-bit pending bitmap of covered but not yet emitted points.
REQ-016 Candidate set = pending | new_hits; selection SHALL be the lowest set bit (fixed priority, bit 0 highest).
REQ-017 Output register SHALL load when out_valid==0 or (out_valid && out_ready), and candidate set nonzero: out_valid<=1, out_index<=COVER_INDEX+sel.
REQ-018 On load, the selected bit SHALL be cleared from pending; remaining candidate bits SHALL be written to pending.
REQ-019 If no load occurs, pending SHALL become pending | new_hits.
REQ-020 If out_valid && out_ready and candidate set empty, out_valid SHALL go 0 next cycle.
REQ-021 While out_valid && !out_ready, out_valid and out_index SHALL remain stable (no drop, no change).
REQ-022 Latency: a first hit on bit k in cycle N with idle output and no lower pending bit SHALL give out_valid=1, out_index=COVER_INDEX+k in cycle N+1.
REQ-023 Throughput: with out_ready held high, one index per cycle until candidate set is empty.
REQ-024 covered_cnt SHALL increment by popcount(new_hits) per cycle; cannot exceed WIDTH.
REQ-025 all_covered SHALL equal (covered == all ones), registered state, no extra latency beyond covered.
REQ-026 Repeated hits on an already covered point SHALL change no state.
REQ-027 clear=1 SHALL zero covered, pending, out_valid, covered_cnt next cycle; valid in that cycle SHALL be ignored.
REQ-028 out_index arithmetic SHALL be 64-bit unsigned; COVER_INDEX+WIDTH-1 not required to fit below COVER_TOTAL.
REQ-029 Block SHALL be fully synthesizable; no DPI calls.

Reset
REQ-030 With reset==0 at a clock edge: covered=0, pending=0, out_valid=0, out_index=0, covered_cnt=0, all_covered=0.
REQ-031 reset SHALL take priority over clear and valid; valid during reset SHALL be discarded.
REQ-032 Reset mid-burst SHALL drop all pending and in-flight indices; no index reported after reset release without a new hit.

Verification
REQ-033 COVER_INDEX=100: valid=0x00004 one cycle, out_ready=1 -> next cycle out_valid=1, out_index=102; then out_valid=0; covered_cnt=1.
REQ-034 valid=0x7FFFF one cycle, out_ready=1 -> indices 100..118 on 19 consecutive cycles in ascending order; covered_cnt=19, all_covered=1.
REQ-035 valid=0x00003, out_ready=0 for 5 cycles -> out_index=100 held stable; raise out_ready -> 100 then 101, each exactly once.
REQ-036 valid=0x00001 repeated 10 cycles -> index 100 emitted once only; covered_cnt=1.
REQ-037 Hits 0x00030 then clear=1 with valid=0x00001 -> all state zero; subsequent valid=0x00010 -> index 104 re-emitted, covered_cnt=1.
REQ-038 Reset asserted while 5 indices pending -> all outputs zero next cycle; no emission after release until new hit.
